// File: rtl/lf_envelope_decim.sv
// LF envelope decimator: boxcar-averages ADC samples captured on adc_clk rising edges
// and feeds them through a hysteresis comparator. Optional run-length counter: LF_ENV_RUNLEN_EN.
module lf_envelope_decim #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        pck0,
  input  logic        rst_n,
  input  logic        adc_clk,
  input  logic [7:0]  adc_d,
  input  logic [7:0]  thr_hi,
  input  logic [7:0]  thr_lo,
  input  logic        clear_ovr,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        env_hi,
  output logic        edge_pulse,
  output logic        overrun,
  output logic [15:0] run_len
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {ST_LOW, ST_HIGH} state_t;

  function automatic logic [7:0] avg_trunc(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] sh;
    sh = sum >> AVG_LOG2;
    return sh[7:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic             adc_clk_q;
  logic             strobe;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum;
  logic             last;
  logic [7:0]       avg_q, avg_d;
  logic             avg_new_q, avg_new_d;

  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             drop;

  state_t           state_q, state_d;
  logic             trans;
  logic             edge_q;

  assign strobe = adc_clk & ~adc_clk_q;
  assign sum    = acc_q + ACC_W'(adc_d);
  assign last   = (cnt_q == CNT_LAST);

  // Accumulation: the completing strobe folds its own sample into the average.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    avg_new_d = 1'b0;
    if (strobe) begin
      if (last) begin
        avg_d     = avg_trunc(sum);
        avg_new_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pck0 or negedge rst_n) begin
    if (!rst_n) begin
      adc_clk_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      avg_new_q <= 1'b0;
    end else begin
      adc_clk_q <= adc_clk;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      avg_new_q <= avg_new_d;
    end
  end

  // Output holding register; a full register that is not being drained drops the new average.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    drop        = 1'b0;
    if (avg_new_q) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = avg_q;
        out_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    overrun_d = overrun_q;
    if (clear_ovr) overrun_d = 1'b0;
    if (drop)      overrun_d = 1'b1;
  end

  // Hysteresis comparator, stepped once per average whether or not it was delivered.
  always_comb begin
    state_d = state_q;
    trans   = 1'b0;
    if (avg_new_q) begin
      if (state_q == ST_LOW) begin
        if (avg_q >= thr_hi) begin
          state_d = ST_HIGH;
          trans   = 1'b1;
        end
      end else begin
        if (avg_q <= thr_lo) begin
          state_d = ST_LOW;
          trans   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pck0 or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      state_q     <= ST_LOW;
      edge_q      <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
      edge_q      <= trans;
    end
  end

`ifdef LF_ENV_RUNLEN_EN
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [15:0] run_len_q, run_len_d;

  // run_len reports the averages spent in the previous state, including the one that ended it.
  always_comb begin
    run_cnt_d = run_cnt_q;
    run_len_d = run_len_q;
    if (avg_new_q) begin
      if (trans) begin
        run_len_d = sat_inc16(run_cnt_q);
        run_cnt_d = '0;
      end else begin
        run_cnt_d = sat_inc16(run_cnt_q);
      end
    end
  end

  always_ff @(posedge pck0 or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
      run_len_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      run_len_q <= run_len_d;
    end
  end

  assign run_len = run_len_q;
`else
  assign run_len = 16'd0;
`endif

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign env_hi     = (state_q == ST_HIGH);
  assign edge_pulse = edge_q;

endmodule

// File: doc/lf_envelope_decim.md
Name: lf_envelope_decim

Overview:
- Downstream consumer of the LF reader's ADC samples. Runs on pck0.
- Detects each rising edge of the adc_clk it is fed and captures adc_d on that edge.
- Boxcar-averages 2^AVG_LOG2 samples into one decimated envelope byte and passes it on with a valid/ready handshake.
- Runs a hysteresis comparator on every average so firmware gets a clean envelope bit and edge strobe instead of raw samples.

Parameters:
- AVG_LOG2, 2: log2 of samples per average; legal range 0..4.
- Derived: ACC_W = 8 + AVG_LOG2, the accumulator width.

Ports:
- pck0  in  1  system clock, 24 MHz.
- rst_n  in  1  reset; asynchronous assert, active-low.
- adc_clk  in  1  ADC clock from the LF read stage, synchronous to pck0.
- adc_d  in  8  ADC sample, valid at the adc_clk rising edge.
- thr_hi  in  8  rise threshold.
- thr_lo  in  8  fall threshold.
- clear_ovr  in  1  clears the sticky overrun flag.
- out_ready  in  1  downstream ready.
- out_data  out  8  averaged sample.
- out_valid  out  1  out_data valid.
- env_hi  out  1  envelope state.
- edge_pulse  out  1  one-cycle strobe on each env_hi change.
- overrun  out  1  sticky; an average was dropped.
- run_len  out  16  run length; see Optional Feature.

Behaviour:
- Reset (asynchronous, rst_n=0): all registers and outputs go to 0, FSM goes to LOW, adc_clk_q=0. A partial accumulation is discarded.
- Strobe:
  - adc_clk_q registers adc_clk.
  - strobe = adc_clk & ~adc_clk_q.
  - adc_d is captured in the cycle strobe=1.
  - adc_clk held high or low produces no strobes.
- Accumulate:
  - On strobe: acc += adc_d and cnt += 1 (cnt is AVG_LOG2 bits wide).
  - When a strobe arrives with cnt == 2^AVG_LOG2-1: avg = (acc + adc_d) >> AVG_LOG2, truncated. acc and cnt then clear in the same cycle.
  - ACC_W guarantees no overflow. AVG_LOG2=0 passes each sample straight through.
  - The avg_new pulse occurs one cycle after the completing strobe.
  - Latency from the completing strobe to out_valid is 2 pck0 cycles.
- Output register, evaluated on avg_new:
  - Register empty, or handshake (out_valid & out_ready) in the same cycle: load avg and set out_valid=1.
  - Register full and out_ready=0: drop avg, keep the old out_data, set overrun=1.
- Without avg_new, a handshake clears out_valid.
- out_data is stable while out_valid=1 and out_ready=0.
- overrun clears only on clear_ovr=1. If clear_ovr and a new drop happen in the same cycle, the set wins.
- Envelope FSM, evaluated only on avg_new:
  - LOW -> HIGH when avg >= thr_hi.
  - HIGH -> LOW when avg <= thr_lo.
  - Otherwise the state holds. env_hi=1 in HIGH.
  - edge_pulse=1 for exactly the cycle after each transition.
  - The FSM runs regardless of out_ready; dropped averages still update it.
  - If thr_lo >= thr_hi the behaviour is deterministic: the rules above apply per average and can toggle on every average.
- Thresholds are sampled at avg_new; they may change at any time.

Optional Feature:
- Macro LF_ENV_RUNLEN_EN.
- Defined:
  - A 16-bit counter increments on each avg_new that does not cause a transition, saturating at 0xFFFF.
  - On a transition, run_len latches count+1 (saturated) in the same cycle edge_pulse rises, and the counter resets to 0.
  - Reset clears both the counter and run_len.
- Undefined: no counter logic; run_len is tied to 0.

Test Plan:
- AVG_LOG2=2, out_ready=1; strobes with adc_d 10,20,30,40 -> out_valid one cycle with out_data=25; acc=0 afterwards.
- Four samples of 255 -> out_data=255, no wrap. Then 255,255,255,254 -> out_data=254 (1019>>2).
- thr_hi=128, thr_lo=96; averages 50,130,110,90,100 -> env_hi 0,1,1,0,0, two edge_pulses. With LF_ENV_RUNLEN_EN: run_len=2 at the rise, 2 at the fall.
- out_ready=0; averages 40 then 60 -> out_data stays 40, overrun=1. clear_ovr -> overrun=0. Then out_ready=1 -> 40 transferred and out_valid=0.
- Handshake coincident with avg_new 77 while holding 40 -> out_data=77, out_valid stays 1, overrun stays 0.
- Two strobes of 200, rst_n pulsed low mid-cycle, then four strobes of 8 -> out_data=8, env_hi=0. adc_clk held high for 100 cycles -> no out_valid.
